// File: rtl/cd_limit_calc.sv
// Converts a requested output frequency into the clock-divider half-period word.
// The quotient CLK_FREQ / (2*freq) is formed by bit-serial restoring division, then clamped to WIDTH.
module cd_limit_calc #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int WIDTH      = 32,
  parameter int FREQ_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FREQ_WIDTH-1:0] req_freq,
  output logic                  req_ready,
  output logic [WIDTH-1:0]      limit,
  output logic                  limit_valid,
  output logic                  err,
  output logic                  sat,
  output logic                  busy
);

  localparam int DIV_BITS = $clog2(CLK_FREQ + 1);
  localparam int RW       = (DIV_BITS + 1 > FREQ_WIDTH + 1) ? DIV_BITS + 1 : FREQ_WIDTH + 1;
  localparam int CW       = $clog2(DIV_BITS);
  localparam logic [DIV_BITS-1:0] DIVIDEND  = DIV_BITS'(CLK_FREQ);
  localparam logic [WIDTH-1:0]    LIMIT_RST = WIDTH'(CLK_FREQ / 2);
  localparam logic [CW-1:0]       CNT_TOP   = CW'(DIV_BITS - 1);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, FINISH} state_t;

  state_t                state_reg, state_next;
  logic [FREQ_WIDTH-1:0] freq_reg, freq_next;
  logic [RW-1:0]         divisor_reg, divisor_next;
  logic [RW-1:0]         rem_reg, rem_next;
  logic [DIV_BITS-1:0]   quot_reg, quot_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [WIDTH-1:0]      limit_reg, limit_next;
  logic                  limit_valid_reg, limit_valid_next;
  logic                  err_reg, err_next;
  logic                  sat_reg, sat_next;

  logic [RW-1:0]    rem_shift;
  logic             rem_ge;
  logic             q_zero;
  logic             q_over;
  logic [WIDTH-1:0] q_fit;

  assign rem_shift = {rem_reg[RW-2:0], DIVIDEND[cnt_reg]};
  assign rem_ge    = (rem_shift >= divisor_reg);
  assign q_zero    = (quot_reg == '0);

  // Quotient bits beyond WIDTH only exist when the clock is fast relative to the limit width.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fit
      if (gi < DIV_BITS) begin : g_bit
        assign q_fit[gi] = quot_reg[gi];
      end else begin : g_pad
        assign q_fit[gi] = 1'b0;
      end
    end
    if (DIV_BITS > WIDTH) begin : g_over
      assign q_over = |quot_reg[DIV_BITS-1:WIDTH];
    end else begin : g_no_over
      assign q_over = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    freq_next        = freq_reg;
    divisor_next     = divisor_reg;
    rem_next         = rem_reg;
    quot_next        = quot_reg;
    cnt_next         = cnt_reg;
    limit_next       = limit_reg;
    limit_valid_next = 1'b0;
    err_next         = 1'b0;
    sat_next         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          freq_next  = req_freq;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (freq_reg == '0) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          divisor_next = RW'({freq_reg, 1'b0});
          rem_next     = '0;
          quot_next    = '0;
          cnt_next     = CNT_TOP;
          state_next   = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_next  = rem_ge ? (rem_shift - divisor_reg) : rem_shift;
        quot_next = {quot_reg[DIV_BITS-2:0], rem_ge};
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == '0) state_next = FINISH;
      end
      FINISH: begin
        limit_valid_next = 1'b1;
        state_next       = IDLE;
        if (q_zero) begin
          limit_next = WIDTH'(1);
          sat_next   = 1'b1;
        end else if (q_over) begin
          limit_next = '1;
          sat_next   = 1'b1;
        end else begin
          limit_next = q_fit;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      freq_reg        <= '0;
      divisor_reg     <= '0;
      rem_reg         <= '0;
      quot_reg        <= '0;
      cnt_reg         <= '0;
      limit_reg       <= LIMIT_RST;
      limit_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      sat_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      freq_reg        <= freq_next;
      divisor_reg     <= divisor_next;
      rem_reg         <= rem_next;
      quot_reg        <= quot_next;
      cnt_reg         <= cnt_next;
      limit_reg       <= limit_next;
      limit_valid_reg <= limit_valid_next;
      err_reg         <= err_next;
      sat_reg         <= sat_next;
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign limit       = limit_reg;
  assign limit_valid = limit_valid_reg;
  assign err         = err_reg;
  assign sat         = sat_reg;

endmodule

// File: tb/tb_cd_limit_calc.sv
// Directed bench for cd_limit_calc: table of frequencies with hand-computed limits,
// plus sequences for error, ignored requests, resets and a 16-bit saturating instance.
module tb_cd_limit_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid16;
  logic [31:0] req_freq, req_freq16;
  logic        req_ready, req_ready16;
  logic [31:0] limit;
  logic [15:0] limit16;
  logic        limit_valid, limit_valid16;
  logic        err, err16, sat, sat16, busy, busy16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cd_limit_calc dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_freq(req_freq),
    .req_ready(req_ready), .limit(limit), .limit_valid(limit_valid),
    .err(err), .sat(sat), .busy(busy)
  );

  cd_limit_calc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .req_valid(req_valid16), .req_freq(req_freq16),
    .req_ready(req_ready16), .limit(limit16), .limit_valid(limit_valid16),
    .err(err16), .sat(sat16), .busy(busy16)
  );

  typedef struct {
    logic [31:0] freq;
    logic [31:0] lim;
    logic        s;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // Handshake at E0, then wait (bounded) for the limit_valid pulse.
  task automatic run_req(input logic [31:0] f, output logic [31:0] lim, output logic s,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    req_freq  = f;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; busy_cnt = 0; lim = '0; s = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      if (limit_valid) begin
        lat = i; lim = limit; s = sat;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] lim;
    logic        s;
    int          lat, bc, seen, ok_idle, ready_low;

    vecs[0] = '{32'd1000,       32'd25_000,     1'b0};
    vecs[1] = '{32'd3,          32'd8_333_333,  1'b0};
    vecs[2] = '{32'd25_000_000, 32'd1,          1'b0};
    vecs[3] = '{32'd30_000_000, 32'd1,          1'b1};
    vecs[4] = '{32'd1,          32'd25_000_000, 1'b0};
    vecs[5] = '{32'd7,          32'd3_571_428,  1'b0};
    vecs[6] = '{32'd12345,      32'd2025,       1'b0};
    vecs[7] = '{32'd12_500_000, 32'd2,          1'b0};
    vecs[8] = '{32'd25_000_001, 32'd1,          1'b1};
    vecs[9] = '{32'hFFFF_FFFF,  32'd1,          1'b1};

    rst = 1'b1; req_valid = 1'b0; req_freq = '0; req_valid16 = 1'b0; req_freq16 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    ok_idle = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (limit != 32'd25_000_000 || !req_ready || busy || limit_valid || err || sat) ok_idle = 0;
    end
    chk("reset_idle_ok", 32'(ok_idle), 32'd1);
    chk("reset_limit16", 32'(limit16), 32'h7840);

    // Table-driven requests, issued back to back
    foreach (vecs[k]) begin
      run_req(vecs[k].freq, lim, s, lat, bc);
      if (lat == 0) chk($sformatf("timeout_f%0d", vecs[k].freq), 32'd0, 32'd28);
      else begin
        chk($sformatf("latency_f%0d", vecs[k].freq), 32'(lat), 32'd28);
        chk($sformatf("limit_f%0d", vecs[k].freq), lim, vecs[k].lim);
        chk($sformatf("sat_f%0d", vecs[k].freq), 32'(s), 32'(vecs[k].s));
        chk($sformatf("busy_cycles_f%0d", vecs[k].freq), 32'(bc), 32'd28);
        chk($sformatf("idle_after_f%0d", vecs[k].freq), 32'({busy, req_ready}), 32'b01);
      end
      @(posedge clk); #1;
      chk($sformatf("pulse_end_f%0d", vecs[k].freq), 32'({limit_valid, sat, err}), 32'd0);
    end

    // Zero frequency: error pulse, then an immediate follow-up request
    @(negedge clk); req_freq = 32'd0; req_valid = 1'b1;
    @(posedge clk); #1 req_freq = 32'd1000;
    @(posedge clk); #1;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_limit_held", limit, 32'd2025 == 32'd0 ? 32'd0 : 32'd1);
    chk("err_no_valid", 32'(limit_valid), 32'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    chk("err_next_accepted", 32'({busy, err}), 32'b10);
    seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (limit_valid) seen = 1;
    end
    chk("after_err_limit", limit, 32'd25_000);

    // Request held during a divide with a different value must be ignored
    @(negedge clk); req_freq = 32'd1000; req_valid = 1'b1;
    @(posedge clk); #1 req_freq = 32'd5;
    seen = 0; ready_low = 1;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      if (req_ready) ready_low = 0;
      @(posedge clk); #1;
      if (limit_valid) begin
        seen = 1;
        req_valid = 1'b0;
      end
    end
    chk("hold_ready_low", 32'(ready_low), 32'd1);
    chk("hold_limit", limit, 32'd25_000);
    @(posedge clk); #1;
    chk("hold_not_requeued", 32'(busy), 32'd0);

    // Reset in the middle of a divide
    @(negedge clk); req_freq = 32'd1000; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_limit", limit, 32'd25_000_000);
    chk("midrst_state", 32'({busy, req_ready}), 32'b01);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (limit_valid) seen = 1;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);

    // Reset and request together: request dropped
    @(negedge clk); rst = 1'b1; req_freq = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
    chk("rst_wins_idle", 32'(busy), 32'd0);

    // 16-bit instance saturates on a 1 Hz request
    @(negedge clk); req_freq16 = 32'd1; req_valid16 = 1'b1;
    @(posedge clk); #1 req_valid16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (limit_valid16) begin
        lat = i;
        chk("w16_limit", 32'(limit16), 32'hFFFF);
        chk("w16_sat_coincident", 32'(sat16), 32'd1);
      end
    end
    chk("w16_latency", 32'(lat), 32'd28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
